// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request, shared-ALU and response signal bundle for alu_share_arbiter
interface alu_share_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [4*NREQ-1:0]  req_op;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [3:0]         alu_op;
    logic [31:0]        alu_out;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_data;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_out, resp_ready,
        output req_ready, alu_a, alu_b, alu_op, resp_valid, resp_id, resp_data
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_out, resp_ready,
        input  req_ready, alu_a, alu_b, alu_op, resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU with a registered response
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);
    logic [IDW-1:0]  rr_ptr_q,     rr_ptr_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q,    resp_id_d;
    logic [31:0]     resp_data_q,  resp_data_d;

    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  grant_idx;
    logic            any_req;
    logic            can_issue;
    logic            accept;

    // (base + step) mod NREQ; base is always below NREQ so one subtraction suffices
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return sum[IDW-1:0];
    endfunction

    // Round-robin scan starting at rr_ptr: first valid requester wins
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any_req && (wrap_idx(rr_ptr_q, k) == IDW'(i)) && bus.req_valid[i]) begin
                    any_req   = 1'b1;
                    grant_idx = IDW'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i] = any_req && (grant_idx == IDW'(i));
        end
    end

    // Steer the granted requester onto the shared ALU; zeros when nobody asks
    always_comb begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                bus.alu_a  = bus.req_a[32*i +: 32];
                bus.alu_b  = bus.req_b[32*i +: 32];
                bus.alu_op = bus.req_op[4*i +: 4];
            end
        end
    end

    // Handshake: accept only when the response slot is empty or draining this cycle
    always_comb begin
        can_issue     = !resp_valid_q || bus.resp_ready;
        bus.req_ready = grant_oh & {NREQ{can_issue}};
        accept        = any_req && can_issue;
    end

    // Response slot and pointer next state: load on accept, clear on drain, else hold
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_id_d    = grant_idx;
            resp_data_d  = bus.alu_out;
            rr_ptr_d     = wrap_idx(grant_idx, 1);
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SRA = 4'd7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   id_count [3];

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NREQ(2), .IDW(2)) b2 ();
    alu_share_arbiter_if #(.NREQ(3), .IDW(2)) b3 ();

    alu_share_arbiter #(.NREQ(2), .IDW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    alu_share_arbiter #(.NREQ(3), .IDW(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    assign b2.alu_out = alu_model(b2.alu_a, b2.alu_b, b2.alu_op);
    assign b3.alu_out = alu_model(b3.alu_a, b3.alu_b, b3.alu_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b2.req_valid  = '0;
        b2.req_a      = '0;
        b2.req_b      = '0;
        b2.req_op     = '0;
        b2.resp_ready = 1'b1;
        b3.req_valid  = '0;
        b3.req_a      = '0;
        b3.req_b      = '0;
        b3.req_op     = '0;
        b3.resp_ready = 1'b1;

        // 1: reset, idle
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_resp_valid", 32'(b2.resp_valid), 32'd0);
        check("rst_resp_data", b2.resp_data, 32'd0);
        check("rst_req_ready", 32'(b2.req_ready), 32'd0);
        check("rst3_resp_valid", 32'(b3.resp_valid), 32'd0);

        // 2: single request 5 + 3
        b2.req_valid      = 2'b01;
        b2.req_a[31:0]    = 32'd5;
        b2.req_b[31:0]    = 32'd3;
        b2.req_op[3:0]    = ALU_ADD;
        #1;
        check("add_req_ready", 32'(b2.req_ready), 32'h1);
        check("add_alu_a", b2.alu_a, 32'd5);
        tick();
        b2.req_valid = 2'b00;
        check("add_resp_valid", 32'(b2.resp_valid), 32'd1);
        check("add_resp_id", 32'(b2.resp_id), 32'd0);
        check("add_resp_data", b2.resp_data, 32'd8);
        tick();
        check("add_drained", 32'(b2.resp_valid), 32'd0);

        // 3: both requesting, alternating grants from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        b2.req_a[31:0]  = 32'd10;
        b2.req_b[31:0]  = 32'd4;
        b2.req_op[3:0]  = ALU_SUB;
        b2.req_a[63:32] = 32'd7;
        b2.req_b[63:32] = 32'd9;
        b2.req_op[7:4]  = ALU_SUB;
        b2.req_valid    = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rr_req_ready", 32'(b2.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check("rr_resp_id", 32'(b2.resp_id), 32'(k % 2));
            check("rr_resp_data", b2.resp_data, (k % 2 == 0) ? 32'd6 : 32'hFFFF_FFFE);
        end

        // 4: backpressure holds the response and blocks new accepts
        b2.resp_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_req_ready", 32'(b2.req_ready), 32'd0);
            tick();
            check("bp_resp_valid", 32'(b2.resp_valid), 32'd1);
            check("bp_resp_id", 32'(b2.resp_id), 32'd1);
            check("bp_resp_data", b2.resp_data, 32'hFFFF_FFFE);
        end
        b2.resp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(b2.req_ready), 32'h1);
        tick();
        b2.req_valid = 2'b00;
        check("bp_new_id", 32'(b2.resp_id), 32'd0);
        check("bp_new_data", b2.resp_data, 32'd6);
        tick();
        check("bp_drained", 32'(b2.resp_valid), 32'd0);

        // 5: accepted SRA dropped by reset
        b2.req_a[63:32] = 32'h8000_0000;
        b2.req_b[63:32] = 32'd4;
        b2.req_op[7:4]  = ALU_SRA;
        b2.req_valid    = 2'b10;
        #1;
        check("sra_req_ready", 32'(b2.req_ready), 32'h2);
        tick();
        b2.req_valid = 2'b00;
        rst_n        = 1'b0;
        check("sra_resp_data", b2.resp_data, 32'hF800_0000);
        check("sra_resp_id", 32'(b2.resp_id), 32'd1);
        tick();
        check("sra_rst_valid", 32'(b2.resp_valid), 32'd0);
        check("sra_rst_data", b2.resp_data, 32'd0);
        check("sra_rst_id", 32'(b2.resp_id), 32'd0);
        rst_n        = 1'b1;
        b2.req_valid = 2'b11;
        #1;
        check("sra_ptr_zero", 32'(b2.req_ready), 32'h1);
        tick();
        b2.req_valid = 2'b00;
        check("sra_post_id", 32'(b2.resp_id), 32'd0);
        tick();
        check("sra_post_drain", 32'(b2.resp_valid), 32'd0);

        // 6: three requesters, nine accepts
        for (int i = 0; i < 3; i++) begin
            b3.req_a[32*i +: 32] = 32'(100 + i);
            b3.req_b[32*i +: 32] = 32'd1;
            b3.req_op[4*i +: 4]  = ALU_ADD;
            id_count[i]          = 0;
        end
        b3.req_valid = 3'b111;
        #1;
        for (int k = 0; k < 9; k++) begin
            check("fair_req_ready", 32'(b3.req_ready), 32'(1 << (k % 3)));
            tick();
            check("fair_resp_id", 32'(b3.resp_id), 32'(k % 3));
            check("fair_resp_data", b3.resp_data, 32'(101 + k % 3));
            if (b3.resp_id < 2'd3) begin
                id_count[b3.resp_id]++;
            end
        end
        b3.req_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            check("fair_count", 32'(id_count[i]), 32'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
